// File: rtl/mc_main_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_main_controller
// Brief    : Main control FSM of the multi-cycle MIPS core, with memory states
//            stretched by MEM_WAIT stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mc_main_controller #(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       ir_write,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       error_flag,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [3:0] c_MEM_WAIT = 4'(MEM_WAIT);
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       w_last;
  logic       w_mem;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_error;

  assign w_last = (r_cnt == c_MEM_WAIT);
  assign w_mem  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

  // Counter restarts whenever the state changes, so every memory state is entered with cnt=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= 4'd0;
      else if (w_mem && (r_cnt < c_MEM_WAIT))
        r_cnt <= r_cnt + 4'd1;
    end
  end

  always_comb begin
    w_next      = S_FETCH;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_error     = 1'b0;
    i_or_d      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_op      = 2'b00;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = 2'b01;
        w_ir_write = w_last;
        w_pc_write = w_last;
        w_next     = w_last ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_RTYPE:       w_next = S_EXECUTE;
          c_OP_BEQ:         w_next = S_BRANCH;
          c_OP_ADDI:        w_next = S_ADDIEX;
          c_OP_J:           w_next = S_JUMP;
          default:          w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        i_or_d = 1'b1;
        w_next = w_last ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        w_reg_write = 1'b1;
      end
      S_MEMWR: begin
        i_or_d      = 1'b1;
        w_mem_write = 1'b1;
        w_next      = w_last ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        w_branch  = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_JUMP: begin
        pc_src     = 2'b10;
        w_pc_write = 1'b1;
      end
      S_ILLEGAL: w_error = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are gated by reset directly so no write escapes while reset is held.
  assign ir_write   = w_ir_write & ~reset;
  assign pc_en      = (w_pc_write | (w_branch & zero)) & ~reset;
  assign mem_write  = w_mem_write & ~reset;
  assign reg_write  = w_reg_write & ~reset;
  assign error_flag = w_error & ~reset;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_main_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_main_controller
// Brief    : Scoreboard bench for mc_main_controller at MEM_WAIT=0 and MEM_WAIT=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_main_controller;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_ILLEGAL = 4'd12;

  logic       clk = 1'b0;
  logic       rst0, rst2;
  logic [5:0] opcode;
  logic       zero;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [18:0] q[$];

  logic       ir0, pe0, io0, mw0, rw0, rd0, mr0, a0, er0;
  logic [1:0] b0, ps0, op0;
  logic [3:0] st0;
  logic       ir2, pe2, io2, mw2, rw2, rd2, mr2, a2, er2;
  logic [1:0] b2, ps2, op2;
  logic [3:0] st2;
  logic [18:0] w_v0, w_v2;

  always #5 clk = ~clk;

  mc_main_controller #(.MEM_WAIT(0)) u_dut0 (
    .clk(clk), .reset(rst0), .opcode(opcode), .zero(zero),
    .ir_write(ir0), .pc_en(pe0), .i_or_d(io0), .mem_write(mw0), .reg_write(rw0),
    .reg_dst(rd0), .mem_to_reg(mr0), .alu_src_a(a0), .alu_src_b(b0), .pc_src(ps0),
    .alu_op(op0), .error_flag(er0), .state(st0)
  );

  mc_main_controller #(.MEM_WAIT(2)) u_dut2 (
    .clk(clk), .reset(rst2), .opcode(opcode), .zero(zero),
    .ir_write(ir2), .pc_en(pe2), .i_or_d(io2), .mem_write(mw2), .reg_write(rw2),
    .reg_dst(rd2), .mem_to_reg(mr2), .alu_src_a(a2), .alu_src_b(b2), .pc_src(ps2),
    .alu_op(op2), .error_flag(er2), .state(st2)
  );

  assign w_v0 = {st0, ir0, pe0, io0, mw0, rw0, rd0, mr0, a0, b0, ps0, op0, er0};
  assign w_v2 = {st2, ir2, pe2, io2, mw2, rw2, rd2, mr2, a2, b2, ps2, op2, er2};

  // Expected output vector for one cycle, taken from the per-state output table.
  function automatic logic [18:0] expv(input logic [3:0] st, input logic last, input logic z);
    logic ir, pe, io, mw, rw, rd, mr, a, er;
    logic [1:0] b, ps, op;
    {ir, pe, io, mw, rw, rd, mr, a, er} = '0;
    b = 2'b00; ps = 2'b00; op = 2'b00;
    case (st)
      S_FETCH:   begin b = 2'b01; ir = last; pe = last; end
      S_DECODE:  b = 2'b11;
      S_MEMADR:  begin a = 1'b1; b = 2'b10; end
      S_MEMRD:   io = 1'b1;
      S_MEMWB:   begin mr = 1'b1; rw = 1'b1; end
      S_MEMWR:   begin io = 1'b1; mw = 1'b1; end
      S_EXECUTE: begin a = 1'b1; op = 2'b10; end
      S_ALUWB:   begin rd = 1'b1; rw = 1'b1; end
      S_BRANCH:  begin a = 1'b1; op = 2'b01; ps = 2'b01; pe = z; end
      S_ADDIEX:  begin a = 1'b1; b = 2'b10; end
      S_ADDIWB:  rw = 1'b1;
      S_JUMP:    begin ps = 2'b10; pe = 1'b1; end
      S_ILLEGAL: er = 1'b1;
      default:   ;
    endcase
    return {st, ir, pe, io, mw, rw, rd, mr, a, b, ps, op, er};
  endfunction

  task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_instr(input int w, input logic [5:0] opc);
    for (int i = 0; i <= w; i++) q.push_back(expv(S_FETCH, i == w, zero));
    q.push_back(expv(S_DECODE, 1'b0, zero));
    case (opc)
      6'b100011: begin
        q.push_back(expv(S_MEMADR, 1'b0, zero));
        for (int i = 0; i <= w; i++) q.push_back(expv(S_MEMRD, 1'b0, zero));
        q.push_back(expv(S_MEMWB, 1'b0, zero));
      end
      6'b101011: begin
        q.push_back(expv(S_MEMADR, 1'b0, zero));
        for (int i = 0; i <= w; i++) q.push_back(expv(S_MEMWR, 1'b0, zero));
      end
      6'b000000: begin
        q.push_back(expv(S_EXECUTE, 1'b0, zero));
        q.push_back(expv(S_ALUWB, 1'b0, zero));
      end
      6'b000100: q.push_back(expv(S_BRANCH, 1'b0, zero));
      6'b001000: begin
        q.push_back(expv(S_ADDIEX, 1'b0, zero));
        q.push_back(expv(S_ADDIWB, 1'b0, zero));
      end
      6'b000010: q.push_back(expv(S_JUMP, 1'b0, zero));
      default:   q.push_back(expv(S_ILLEGAL, 1'b0, zero));
    endcase
  endtask

  // Compare up to n queued cycles against the selected DUT, one per cycle.
  task automatic drain(input int sel, input int n);
    logic [18:0] e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      e = q.pop_front();
      check($sformatf("dut%0d_st%0d", sel, e[18:15]), (sel != 0) ? w_v2 : w_v0, e);
      @(negedge clk);
    end
  endtask

  task automatic run(input int sel, input logic [5:0] opc, input logic z);
    opcode = opc;
    zero   = z;
    push_instr((sel != 0) ? 2 : 0, opc);
    drain(sel, 64);
  endtask

  initial begin
    rst0 = 1'b1; rst2 = 1'b1; opcode = 6'b000000; zero = 1'b0;
    repeat (3) @(negedge clk);
    check("reset0", w_v0, expv(S_FETCH, 1'b0, 1'b0));
    check("reset2", w_v2, expv(S_FETCH, 1'b0, 1'b0));
    rst0 = 1'b0;
    #1;
    run(0, 6'b000000, 1'b0);
    run(0, 6'b100011, 1'b0);
    run(0, 6'b000100, 1'b1);
    run(0, 6'b000100, 1'b0);
    run(0, 6'b111111, 1'b0);
    run(0, 6'b001000, 1'b0);
    run(0, 6'b000010, 1'b0);
    run(0, 6'b101011, 1'b0);
    check("fetch_after_seq", w_v0, expv(S_FETCH, 1'b1, 1'b0));

    rst0 = 1'b1;
    rst2 = 1'b0;
    #1;
    run(1, 6'b101011, 1'b0);
    run(1, 6'b100011, 1'b0);
    run(1, 6'b000000, 1'b0);
    check("fetch2_first", w_v2, expv(S_FETCH, 1'b0, 1'b0));

    rst2 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    #1;
    opcode = 6'b100011;
    push_instr(0, opcode);
    drain(0, 4);
    check("memwb_before_rst", w_v0, q.pop_front());
    #1 rst0 = 1'b1;
    #1;
    check("async_rst_in_memwb", w_v0, expv(S_FETCH, 1'b0, 1'b0));
    @(negedge clk);
    rst0 = 1'b0;
    #1;
    check("fetch_after_rst", w_v0, expv(S_FETCH, 1'b1, 1'b0));
    run(0, 6'b000000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
